idli_sqi_ctrl_m: RTL and testbench



---
 rtl/idli_sqi_ctrl_m.sv | 268 ++++++++++++++++++++++++++
 tb/tb_idli_sqi_ctrl_m.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idli_sqi_ctrl_m.sv
// -----------------------------------------------------------------------------
// idli_sqi_ctrl_m
//
// Sequencer for one external SQI (quad-SPI) serial SRAM bank. A single 16-bit
// word read or write is accepted over a ready/req handshake and turned into
// one SQI frame:
//
//   CMD (2 nibbles) -> ADDR (6 nibbles) -> [DUMMY (2 nibbles), reads only]
//   -> DATA (4 nibbles) -> DONE (ack, 1 cycle) -> GAP (1 cycle) -> IDLE
//
// Every nibble occupies a slot of two core clocks:
//   phase 0 : sck = 0, new nibble presented on sio
//   phase 1 : sck = 1, sio held (the memory samples on the sck rising edge)
// So sck runs at gck/2, and sio only ever changes while sck is low.
//
// Ports
//   i_sqi_gck      core clock, all state changes on its rising edge
//   i_sqi_rst_n    asynchronous active-low reset
//   o_sqi_ready    idle and able to accept a request
//   i_sqi_req      request valid, accepted when req & ready on a rising edge
//   i_sqi_wr       1 = write, 0 = read (sampled at accept)
//   i_sqi_addr     16-bit word address (sampled at accept)
//   i_sqi_wdata    16-bit write data (sampled at accept)
//   o_sqi_ack      one-cycle completion pulse
//   o_sqi_rdata    read data, valid with ack, held until the next read ends
//   o_sqi_sck      serial clock to the memory
//   o_sqi_cs       chip select to the memory, active low
//   o_sqi_sio      nibble driven towards the memory
//   o_sqi_sio_oe   1 = controller drives SIO, 0 = memory drives SIO
//   i_sqi_sio      nibble returned by the memory
// -----------------------------------------------------------------------------
module idli_sqi_ctrl_m #(
   parameter logic [7:0] CMD_RD = 8'h03,
   parameter logic [7:0] CMD_WR = 8'h02
) (
   input  logic        i_sqi_gck,
   input  logic        i_sqi_rst_n,
   output logic        o_sqi_ready,
   input  logic        i_sqi_req,
   input  logic        i_sqi_wr,
   input  logic [15:0] i_sqi_addr,
   input  logic [15:0] i_sqi_wdata,
   output logic        o_sqi_ack,
   output logic [15:0] o_sqi_rdata,
   output logic        o_sqi_sck,
   output logic        o_sqi_cs,
   output logic [3:0]  o_sqi_sio,
   output logic        o_sqi_sio_oe,
   input  logic [3:0]  i_sqi_sio
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DUMMY,
      S_DATA,
      S_DONE,
      S_GAP
   } state_t;

   // ---------------------------------------------------------------------------
   // State and transaction registers
   // ---------------------------------------------------------------------------
   state_t      r_state;
   logic [3:0]  r_slot;     // nibble slot within the current state
   logic        r_phase;    // 0 = sck low half, 1 = sck high half
   logic        r_wr;
   logic [15:0] r_addr;
   logic [15:0] r_wdata;
   logic [11:0] r_shift;    // first three read nibbles; the fourth goes straight to rdata

   // Where the frame goes when the current slot ends, and what it drives there
   state_t      w_next_state;
   logic [3:0]  w_next_slot;
   logic        w_last_slot;
   logic [3:0]  w_next_nib;
   logic        w_next_oe;

   // ---------------------------------------------------------------------------
   // Nibble that belongs on SIO for a given (state, slot) of the frame.
   // MSB nibble first throughout. The memory address is a byte address, so the
   // word address is shifted left by one and zero-extended to 24 bits.
   // Slots with the memory driving (dummy, read data) carry zero.
   // ---------------------------------------------------------------------------
   function automatic logic [3:0] f_nibble(
      input state_t      st,
      input logic [3:0]  slot,
      input logic        wr,
      input logic [15:0] addr,
      input logic [15:0] wdata
   );
      logic [7:0]  cmd;
      logic [23:0] a24;
      logic [3:0]  nib;
      cmd = wr ? CMD_WR : CMD_RD;
      a24 = {7'b0, addr, 1'b0};
      nib = 4'h0;
      case (st)
         S_CMD:   nib = (slot == 4'd0) ? cmd[7:4] : cmd[3:0];
         S_ADDR: begin
            case (slot)
               4'd0:    nib = a24[23:20];
               4'd1:    nib = a24[19:16];
               4'd2:    nib = a24[15:12];
               4'd3:    nib = a24[11:8];
               4'd4:    nib = a24[7:4];
               4'd5:    nib = a24[3:0];
               default: nib = 4'h0;
            endcase
         end
         S_DATA: begin
            if (wr) begin
               case (slot)
                  4'd0:    nib = wdata[15:12];
                  4'd1:    nib = wdata[11:8];
                  4'd2:    nib = wdata[7:4];
                  4'd3:    nib = wdata[3:0];
                  default: nib = 4'h0;
               endcase
            end
         end
         default: nib = 4'h0;
      endcase
      return nib;
   endfunction

   // ---------------------------------------------------------------------------
   // Successor of the current slot. Only consulted at the end of phase 1 of a
   // frame state; the slot counter restarts at zero on every state entry.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a value before any branch, so no
      // path can leave one unassigned and infer a latch.
      w_last_slot  = 1'b0;
      w_next_state = r_state;

      case (r_state)
         S_CMD:   w_last_slot = (r_slot == 4'd1);
         S_ADDR:  w_last_slot = (r_slot == 4'd5);
         S_DUMMY: w_last_slot = (r_slot == 4'd1);
         S_DATA:  w_last_slot = (r_slot == 4'd3);
         default: w_last_slot = 1'b0;
      endcase

      if (w_last_slot) begin
         case (r_state)
            S_CMD:   w_next_state = S_ADDR;
            S_ADDR:  w_next_state = r_wr ? S_DATA : S_DUMMY;  // writes skip the dummy byte
            S_DUMMY: w_next_state = S_DATA;
            S_DATA:  w_next_state = S_DONE;
            default: w_next_state = r_state;
         endcase
      end

      w_next_slot = w_last_slot ? 4'd0 : r_slot + 4'd1;
      w_next_nib  = f_nibble(w_next_state, w_next_slot, r_wr, r_addr, r_wdata);
      // The controller owns SIO for command, address and write data only
      w_next_oe   = (w_next_state == S_CMD) || (w_next_state == S_ADDR) ||
                    ((w_next_state == S_DATA) && r_wr);
   end

   // ---------------------------------------------------------------------------
   // Frame sequencer. All pin outputs are registered here so the memory sees
   // glitch-free sck/cs/sio straight from flops.
   // ---------------------------------------------------------------------------
   // NOTE: state and outputs use non-blocking assignments so every register
   // in this block sees the pre-edge values of the others, whatever the order
   // of the statements below.
   always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
      if (!i_sqi_rst_n) begin
         // NOTE: the captured request and shift register are reset along with
         // the control state; they are few bits and this keeps them defined
         // from the first cycle instead of carrying X into the first frame.
         r_state      <= S_IDLE;
         r_slot       <= 4'd0;
         r_phase      <= 1'b0;
         r_wr         <= 1'b0;
         r_addr       <= 16'h0000;
         r_wdata      <= 16'h0000;
         r_shift      <= 12'h000;
         o_sqi_ready  <= 1'b1;
         o_sqi_ack    <= 1'b0;
         o_sqi_rdata  <= 16'h0000;
         o_sqi_sck    <= 1'b0;
         o_sqi_cs     <= 1'b1;
         o_sqi_sio    <= 4'h0;
         o_sqi_sio_oe <= 1'b0;
      end else begin
         o_sqi_ack <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (i_sqi_req && o_sqi_ready) begin
                  r_wr         <= i_sqi_wr;
                  r_addr       <= i_sqi_addr;
                  r_wdata      <= i_sqi_wdata;
                  r_state      <= S_CMD;
                  r_slot       <= 4'd0;
                  r_phase      <= 1'b0;
                  o_sqi_ready  <= 1'b0;
                  o_sqi_cs     <= 1'b0;
                  o_sqi_sck    <= 1'b0;
                  o_sqi_sio_oe <= 1'b1;
                  // First command nibble goes out together with cs falling
                  o_sqi_sio    <= i_sqi_wr ? CMD_WR[7:4] : CMD_RD[7:4];
               end
            end

            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
               if (!r_phase) begin
                  // Second half of the slot: raise sck, hold sio
                  r_phase   <= 1'b1;
                  o_sqi_sck <= 1'b1;
               end else begin
                  r_phase   <= 1'b0;
                  o_sqi_sck <= 1'b0;
                  r_state   <= w_next_state;
                  r_slot    <= w_next_slot;

                  // Read data is sampled on the edge that ends each data slot,
                  // i.e. while sck is still high and the memory output is stable
                  if ((r_state == S_DATA) && !r_wr) begin
                     r_shift <= {r_shift[7:0], i_sqi_sio};
                  end

                  if (w_next_state == S_DONE) begin
                     o_sqi_cs     <= 1'b1;
                     o_sqi_sio_oe <= 1'b0;
                     o_sqi_sio    <= 4'h0;
                     o_sqi_ack    <= 1'b1;
                     if (!r_wr) begin
                        o_sqi_rdata <= {r_shift, i_sqi_sio};
                     end
                  end else begin
                     o_sqi_sio    <= w_next_nib;
                     o_sqi_sio_oe <= w_next_oe;
                  end
               end
            end

            S_DONE: begin
               r_state <= S_GAP;
               r_slot  <= 4'd0;
            end

            // Extra cs-high cycle so the memory always sees at least two
            // cycles of deselect between frames, even with req held high
            S_GAP: begin
               r_state     <= S_IDLE;
               o_sqi_ready <= 1'b1;
            end

            default: begin
               r_state      <= S_IDLE;
               r_slot       <= 4'd0;
               r_phase      <= 1'b0;
               o_sqi_ready  <= 1'b1;
               o_sqi_sck    <= 1'b0;
               o_sqi_cs     <= 1'b1;
               o_sqi_sio    <= 4'h0;
               o_sqi_sio_oe <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// -----------------------------------------------------------------------------
// tb_idli_sqi_ctrl_m
//
// Bench for idli_sqi_ctrl_m. A cycle-indexed reference model predicts every
// output on every cycle from the frame layout (cycles since accept, slot =
// cycle/2, nibble list from a flat 48-bit frame word). A behavioural SQI
// memory sits on the pins, decodes command/address, stores writes and returns
// read data. Directed scenarios pin the model with literal nibble lists, ack
// cycles and read data; a randomized run follows.
// -----------------------------------------------------------------------------
module tb_idli_sqi_ctrl_m;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        req   = 1'b0;
   logic        wr    = 1'b0;
   logic [15:0] addr  = 16'h0000;
   logic [15:0] wdata = 16'h0000;
   logic [3:0]  sio_in = 4'h0;

   logic        ready, ack, sck, cs, oe;
   logic [15:0] rdata;
   logic [3:0]  sio;

   idli_sqi_ctrl_m dut (
      .i_sqi_gck    (clk),
      .i_sqi_rst_n  (rst_n),
      .o_sqi_ready  (ready),
      .i_sqi_req    (req),
      .i_sqi_wr     (wr),
      .i_sqi_addr   (addr),
      .i_sqi_wdata  (wdata),
      .o_sqi_ack    (ack),
      .o_sqi_rdata  (rdata),
      .o_sqi_sck    (sck),
      .o_sqi_cs     (cs),
      .o_sqi_sio    (sio),
      .o_sqi_sio_oe (oe),
      .i_sqi_sio    (sio_in)
   );

   initial forever #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic logic [15:0] f_default(input logic [15:0] a);
      return a ^ 16'hC3A5;
   endfunction

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   int          m_t = 0;              // 0 = idle, else cycles since accept
   logic        m_wr = 1'b0;
   logic [15:0] m_addr = 16'h0, m_wdata = 16'h0, m_exp_rd = 16'h0, m_rdata = 16'h0;
   logic [3:0]  m_nib [12];
   int          m_acc_cyc = 0;
   logic [15:0] ref_mem [logic [15:0]];

   // Monitor of the DUT pins, cleared at every accept
   logic [3:0]  mon_nibs [$];
   int          mon_cs_low = 0, mon_oe_low = 0, mon_ack_k = 0, mon_n_ack = 0, mon_sck_hi = 0;
   logic [15:0] mon_rdata = 16'h0;

   // {ready, ack, rdata, sck, cs, sio, oe}
   function automatic logic [24:0] model_exp();
      int n, slot;
      logic r, a, k, c, o;
      logic [3:0] s;
      n = m_wr ? 24 : 28;
      r = 1'b0; a = 1'b0; k = 1'b0; c = 1'b1; s = 4'h0; o = 1'b0;
      if (m_t == 0) begin
         r = 1'b1;
      end else if (m_t <= n) begin
         slot = (m_t - 1) / 2;
         c = 1'b0;
         k = ((m_t - 1) % 2) == 1;
         if (m_wr || slot < 8) begin
            o = 1'b1;
            s = m_nib[slot];
         end
      end else if (m_t == n + 1) begin
         a = 1'b1;
      end
      return {r, a, m_rdata, k, c, s, o};
   endfunction

   task automatic model_step();
      int n;
      logic [47:0] fr;
      n = m_wr ? 24 : 28;
      if (m_t == 0) begin
         if (req) begin
            m_wr = wr; m_addr = addr; m_wdata = wdata;
            fr = {(wr ? 8'h02 : 8'h03), 7'b0, addr, 1'b0, wdata};
            for (int i = 0; i < 12; i++) m_nib[i] = fr[47 - 4*i -: 4];
            m_exp_rd  = ref_mem.exists(addr) ? ref_mem[addr] : f_default(addr);
            m_acc_cyc = cyc + 1;
            m_t = 1;
            mon_nibs.delete();
            mon_cs_low = 0;
            mon_oe_low = 0;
         end
      end else if (m_t == n + 2) begin
         m_t = 0;
      end else begin
         m_t++;
         if (m_t == n + 1) begin
            if (m_wr) ref_mem[m_addr] = m_wdata;
            else      m_rdata = m_exp_rd;
         end
      end
   endtask

   // Compare on the falling edge, well away from the active edge
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         m_t = 0;
         m_rdata = 16'h0;
      end
      check("cycle_outputs", {7'b0, ready, ack, rdata, sck, cs, sio, oe}, {7'b0, model_exp()});
      if (rst_n) begin
         if (sck) mon_sck_hi++;
         if (!cs) begin
            mon_cs_low++;
            if (!sck) begin
               mon_nibs.push_back(sio);
               if (!oe) mon_oe_low++;
            end
         end
         if (ack) begin
            mon_n_ack++;
            mon_ack_k = cyc - m_acc_cyc + 1;
            mon_rdata = rdata;
         end
         model_step();
      end
   end

   // ---------------------------------------------------------------------------
   // Behavioural SQI SRAM on the pins
   // ---------------------------------------------------------------------------
   logic [15:0] slave_mem [logic [15:0]];
   int          s_cnt = 0;
   logic [7:0]  s_cmd = 8'h0;
   logic [23:0] s_addr = 24'h0;
   logic [15:0] s_wdat = 16'h0, s_rword = 16'h0;

   initial forever begin
      @(posedge sck or posedge cs);
      if (cs) begin
         if (s_cnt == 12 && s_cmd == 8'h02) slave_mem[s_addr[16:1]] = s_wdat;
         s_cnt = 0;
      end else begin
         if (s_cnt < 2)       s_cmd  = {s_cmd[3:0], sio};
         else if (s_cnt < 8)  s_addr = {s_addr[19:0], sio};
         else if (s_cmd == 8'h02 && s_cnt < 12) s_wdat = {s_wdat[11:0], sio};
         if (s_cnt == 7)
            s_rword = slave_mem.exists(s_addr[16:1]) ? slave_mem[s_addr[16:1]] : f_default(s_addr[16:1]);
         // Data for slot n is presented during its sck-high half
         if (s_cmd == 8'h03 && s_cnt >= 10 && s_cnt < 14) sio_in = s_rword[15 - 4*(s_cnt - 10) -: 4];
         else                                              sio_in = 4'($urandom);
         s_cnt++;
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input bit drop, output int acc);
      bit ok;
      ok = 1'b0;
      acc = 0;
      wr = w; addr = a; wdata = d; req = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (ready && rst_n) begin
            @(posedge clk);
            #1;
            acc = cyc;
            ok = 1'b1;
         end
      end
      if (!ok) check("req_accept_timeout", 32'd0, 32'd1);
      if (drop) req = 1'b0;
   endtask

   task automatic wait_ack(input int bound);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk);
         if (ack) seen = 1'b1;
      end
      if (!seen) check("ack_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   logic [3:0]  exp_wr [12] = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h2, 4'h4, 4'h6, 4'h8, 4'hB, 4'hE, 4'hE, 4'hF};
   logic [3:0]  exp_rd [8]  = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2};
   logic [3:0]  exp_ig [12] = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h8, 4'h6, 4'h4, 4'h2, 4'h1, 4'h3, 4'h5, 4'h7};
   logic [15:0] addr_set [8] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000,
                                 16'h1234, 16'h00FF, 16'h0ABC, 16'h7FFE};

   function automatic logic [31:0] nib_at(input int i);
      return (i < mon_nibs.size()) ? {28'h0, mon_nibs[i]} : 32'h10;
   endfunction

   initial begin
      int acc1, acc2, n0;
      ref_mem[16'h0001]   = 16'hA5C3;
      slave_mem[16'h0001] = 16'hA5C3;

      // Reset
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", {31'b0, ready}, 32'd1);
      check("reset_cs",    {31'b0, cs},    32'd1);
      check("reset_sck",   {31'b0, sck},   32'd0);
      check("reset_oe",    {31'b0, oe},    32'd0);
      check("reset_ack",   {31'b0, ack},   32'd0);
      check("reset_rdata", {16'b0, rdata}, 32'd0);
      rst_n = 1'b1;
      mon_sck_hi = 0;
      repeat (10) @(posedge clk);
      #1;
      check("idle_sck_quiet", mon_sck_hi, 32'd0);

      // Write 0x1234 <- 0xBEEF
      do_req(1'b1, 16'h1234, 16'hBEEF, 1'b1, acc1);
      wait_ack(40);
      check("wr_nibble_count", mon_nibs.size(), 32'd12);
      for (int i = 0; i < 12; i++) check($sformatf("wr_nibble%0d", i), nib_at(i), {28'h0, exp_wr[i]});
      check("wr_cs_low_cycles", mon_cs_low, 32'd24);
      check("wr_oe_low_slots",  mon_oe_low, 32'd0);
      check("wr_ack_cycle",     mon_ack_k,  32'd25);

      // Read 0x0001 -> 0xA5C3
      do_req(1'b0, 16'h0001, 16'h0000, 1'b1, acc1);
      wait_ack(40);
      for (int i = 0; i < 8; i++) check($sformatf("rd_nibble%0d", i), nib_at(i), {28'h0, exp_rd[i]});
      check("rd_oe_low_slots", mon_oe_low, 32'd6);
      check("rd_ack_cycle",    mon_ack_k,  32'd29);
      check("rd_data_at_ack",  {16'h0, mon_rdata}, 32'hA5C3);

      // Back-to-back with req held: write then read of the same word
      n0 = mon_n_ack;
      do_req(1'b1, 16'h2222, 16'h5555, 1'b0, acc1);
      do_req(1'b0, 16'h2222, 16'h0000, 1'b1, acc2);
      check("b2b_accept_gap", acc2 - acc1, 32'd27);
      wait_ack(40);
      check("b2b_ack_count", mon_n_ack - n0, 32'd2);
      check("b2b_readback",  {16'h0, mon_rdata}, 32'h5555);

      // Request raised mid-frame is ignored until the frame ends
      do_req(1'b1, 16'h4321, 16'h1357, 1'b1, acc1);
      repeat (4) @(posedge clk);
      #1;
      wr = 1'b0; addr = 16'hFFFF; req = 1'b1;
      wait_ack(40);
      for (int i = 0; i < 12; i++) check($sformatf("busy_req_nibble%0d", i), nib_at(i), {28'h0, exp_ig[i]});
      do_req(1'b0, 16'hFFFF, 16'h0000, 1'b1, acc2);
      check("held_req_accept_gap", acc2 - acc1, 32'd27);
      wait_ack(40);
      check("held_req_rdata", {16'h0, mon_rdata}, 32'h3C5A);

      // Reset during ADDR slot 3 of a write
      n0 = mon_n_ack;
      do_req(1'b1, 16'h0ABC, 16'h7777, 1'b1, acc1);
      repeat (10) @(posedge clk);
      #1;
      check("pre_reset_cs_low", {31'b0, cs}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("midrst_cs",    {31'b0, cs},    32'd1);
      check("midrst_oe",    {31'b0, oe},    32'd0);
      check("midrst_sck",   {31'b0, sck},   32'd0);
      check("midrst_ready", {31'b0, ready}, 32'd1);
      check("midrst_ack",   {31'b0, ack},   32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("midrst_no_ack", mon_n_ack - n0, 32'd0);
      do_req(1'b0, 16'h0ABC, 16'h0000, 1'b1, acc1);
      wait_ack(40);
      check("midrst_then_read", {16'h0, mon_rdata}, 32'hC919);

      // Randomized traffic over a small address set so reads hit written words
      for (int t = 0; t < 60; t++) begin
         int g;
         g = $urandom_range(0, 3);
         do_req(1'($urandom_range(0, 1)), addr_set[$urandom_range(0, 7)], 16'($urandom), (g != 0), acc1);
         if (g != 0) begin
            wait_ack(40);
            repeat (g) @(posedge clk);
            #1;
         end
      end
      req = 1'b0;
      repeat (40) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
